// File: rtl/reg_file_flags_pkg.sv
// Shared types and constants for the operand-supply register file and its status flags.
// Flag bit positions follow the {SC, Zero, Parity, OutBit} ordering used by the ALU.
package reg_file_flags_pkg;

    localparam int D_WIDTH_DEF = 8;
    localparam int A_WIDTH_DEF = 3;
    localparam int FLAG_W      = 4;

    localparam int FLAG_SC     = 3;
    localparam int FLAG_ZERO   = 2;
    localparam int FLAG_PARITY = 1;
    localparam int FLAG_OUTBIT = 0;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWAP2 = 1'b1
    } rf_state_t;

    // Bits selected by m take the new value d; all other bits keep q.
    function automatic logic [FLAG_W-1:0] masked_load(
        input logic [FLAG_W-1:0] q,
        input logic [FLAG_W-1:0] d,
        input logic [FLAG_W-1:0] m
    );
        return (q & ~m) | (d & m);
    endfunction

endpackage

// File: rtl/reg_file_flags_if.sv
// Operand/flag bus between the controller (master) and the register file (slave).
interface reg_file_flags_if #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 3
);
    logic [A_WIDTH-1:0] RaddrA;
    logic [A_WIDTH-1:0] RaddrB;
    logic [D_WIDTH-1:0] DataOutA;
    logic [D_WIDTH-1:0] DataOutB;
    logic               WriteEn;
    logic [A_WIDTH-1:0] Waddr;
    logic [D_WIDTH-1:0] DataIn;
    logic               SwapReq;
    logic               FlagWen;
    logic [3:0]         FlagMask;
    logic [3:0]         FlagsIn;
    logic [3:0]         Flags;
    logic               SC_out;
    logic               Busy;

    modport master (
        output RaddrA, RaddrB, WriteEn, Waddr, DataIn, SwapReq, FlagWen, FlagMask, FlagsIn,
        input  DataOutA, DataOutB, Flags, SC_out, Busy
    );

    modport slave (
        input  RaddrA, RaddrB, WriteEn, Waddr, DataIn, SwapReq, FlagWen, FlagMask, FlagsIn,
        output DataOutA, DataOutB, Flags, SC_out, Busy
    );
endinterface

// File: rtl/reg_file_flags_flag_reg.sv
// 4-bit status register with per-bit load mask; bits outside the mask hold.
module flag_reg
    import reg_file_flags_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Wen,
    input  logic [FLAG_W-1:0] Mask,
    input  logic [FLAG_W-1:0] D,
    output logic [FLAG_W-1:0] Q
);

    // Masked flag capture with synchronous clear.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Q <= {FLAG_W{1'b0}};
        end else if (Wen) begin
            Q <= masked_load(Q, D, Mask);
        end else begin
            Q <= Q;
        end
    end

endmodule

// File: rtl/reg_file_flags.sv
// 8x8 register file feeding the ALU, with status flags and a two-cycle SWAP over one write port.
// Reads are deliberately unbypassed: a bypass would close a combinational loop through the ALU.
module reg_file_flags
    import reg_file_flags_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    reg_file_flags_if.slave bus
);

    localparam int NUM_REGS = 2 ** A_WIDTH;

    logic [D_WIDTH-1:0] regs_r [NUM_REGS];
    rf_state_t          state_r;
    logic [D_WIDTH-1:0] tmp_r;
    logic [A_WIDTH-1:0] saddr_r;
    logic               busy_s;
    logic               flag_wen_s;
    logic [FLAG_W-1:0]  flags_s;

    assign busy_s     = (state_r == RF_SWAP2);
    assign flag_wen_s = bus.FlagWen & ~busy_s;

    assign bus.DataOutA = regs_r[bus.RaddrA];
    assign bus.DataOutB = regs_r[bus.RaddrB];
    assign bus.Busy     = busy_s;
    assign bus.Flags    = flags_s;
    assign bus.SC_out   = flags_s[FLAG_SC];

    // Storage, swap sequencing and swap temporary; a started swap takes the write port from WriteEn.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {D_WIDTH{1'b0}};
            end
            state_r <= RF_IDLE;
            tmp_r   <= {D_WIDTH{1'b0}};
            saddr_r <= {A_WIDTH{1'b0}};
        end else begin
            case (state_r)
                RF_IDLE: begin
                    if (bus.SwapReq && (bus.RaddrA != bus.RaddrB)) begin
                        regs_r[bus.RaddrB] <= regs_r[bus.RaddrA];
                        tmp_r              <= regs_r[bus.RaddrB];
                        saddr_r            <= bus.RaddrA;
                        state_r            <= RF_SWAP2;
                    end else if (bus.WriteEn) begin
                        regs_r[bus.Waddr]  <= bus.DataIn;
                    end else begin
                        state_r            <= RF_IDLE;
                    end
                end
                RF_SWAP2: begin
                    regs_r[saddr_r] <= tmp_r;
                    state_r         <= RF_IDLE;
                end
                default: begin
                    state_r <= RF_IDLE;
                end
            endcase
        end
    end

    flag_reg u_flag_reg (
        .Clk   (Clk),
        .Reset (Reset),
        .Wen   (flag_wen_s),
        .Mask  (bus.FlagMask),
        .D     (bus.FlagsIn),
        .Q     (flags_s)
    );

endmodule

// File: tb/tb_reg_file_flags.sv
// Scoreboard bench for reg_file_flags: a reference model pushes expectations, a drain step compares them.
module tb_reg_file_flags;

    localparam int K_REGA  = 0;
    localparam int K_REGB  = 1;
    localparam int K_FLAGS = 2;
    localparam int K_SC    = 3;
    localparam int K_BUSY  = 4;

    typedef struct {
        string      tag;
        int         kind;
        int         addr;
        logic [7:0] exp;
    } exp_t;

    logic Clk;
    logic Reset;
    reg_file_flags_if #(.D_WIDTH(8), .A_WIDTH(3)) bus ();

    reg_file_flags dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    exp_t       sb_q[$];
    logic [7:0] mdl [8];
    logic [3:0] mflags;
    int         errors = 0;
    int         checks = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input int kind, input int addr, input logic [7:0] exp);
        exp_t e;
        e.tag = tag; e.kind = kind; e.addr = addr; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic push_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            push($sformatf("%s_r%0d", tag, i), (i % 2 == 0) ? K_REGA : K_REGB, i, mdl[i]);
        end
        push({tag, "_flags"}, K_FLAGS, 0, {4'b0000, mflags});
        push({tag, "_sc"}, K_SC, 0, {7'b0000000, mflags[3]});
        push({tag, "_busy"}, K_BUSY, 0, 8'h00);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_REGA:  begin bus.RaddrA = 3'(e.addr); #1; check_eq(e.tag, bus.DataOutA, e.exp); end
                K_REGB:  begin bus.RaddrB = 3'(e.addr); #1; check_eq(e.tag, bus.DataOutB, e.exp); end
                K_FLAGS: begin #1; check_eq(e.tag, {4'b0000, bus.Flags}, e.exp); end
                K_SC:    begin #1; check_eq(e.tag, {7'b0000000, bus.SC_out}, e.exp); end
                default: begin #1; check_eq(e.tag, {7'b0000000, bus.Busy}, e.exp); end
            endcase
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        mflags = 4'b0000;
    endtask

    task automatic write_op(input logic [2:0] a, input logic [7:0] d);
        @(negedge Clk);
        bus.Waddr = a; bus.DataIn = d; bus.WriteEn = 1'b1;
        @(negedge Clk);
        bus.WriteEn = 1'b0;
        mdl[a] = d;
    endtask

    task automatic flag_op(input logic [3:0] m, input logic [3:0] v);
        @(negedge Clk);
        bus.FlagWen = 1'b1; bus.FlagMask = m; bus.FlagsIn = v;
        @(negedge Clk);
        bus.FlagWen = 1'b0;
        mflags = (mflags & ~m) | (v & m);
    endtask

    // Swap request with optional same-cycle write/flag load, junk write+flag load during SWAP2.
    task automatic swap_op(input logic nowait, input logic [2:0] a, input logic [2:0] b,
                           input logic iw, input logic [2:0] iwa, input logic [7:0] iwd,
                           input logic ifw, input logic [3:0] ifm, input logic [3:0] ifi,
                           input logic [2:0] jwa, input logic [7:0] jwd);
        logic [7:0] t;
        if (!nowait) @(negedge Clk);
        bus.RaddrA = a; bus.RaddrB = b; bus.SwapReq = 1'b1;
        bus.WriteEn = iw; bus.Waddr = iwa; bus.DataIn = iwd;
        bus.FlagWen = ifw; bus.FlagMask = ifm; bus.FlagsIn = ifi;
        if (ifw) mflags = (mflags & ~ifm) | (ifi & ifm);
        @(negedge Clk);
        if (a != b) begin
            t = mdl[b];
            mdl[b] = mdl[a];
            bus.SwapReq = 1'b1; bus.WriteEn = 1'b1; bus.Waddr = jwa; bus.DataIn = jwd;
            bus.FlagWen = 1'b1; bus.FlagMask = 4'hF; bus.FlagsIn = ~mflags;
            push("swap_busy", K_BUSY, 0, 8'h01);
            push("swap_mid", K_REGB, b, mdl[b]);
            drain();
            @(negedge Clk);
            mdl[a] = t;
        end else if (iw) begin
            mdl[iwa] = iwd;
        end
        bus.SwapReq = 1'b0; bus.WriteEn = 1'b0; bus.FlagWen = 1'b0;
        push("swap_done_busy", K_BUSY, 0, 8'h00);
        drain();
    endtask

    initial begin
        Reset = 1'b1;
        bus.RaddrA = 3'd0; bus.RaddrB = 3'd0; bus.WriteEn = 1'b0; bus.Waddr = 3'd0;
        bus.DataIn = 8'h00; bus.SwapReq = 1'b0; bus.FlagWen = 1'b0;
        bus.FlagMask = 4'h0; bus.FlagsIn = 4'h0;
        clear_model();

        // 1: reset state
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        push_all("t1"); drain();

        // 2: write visible only after the edge
        @(negedge Clk);
        bus.Waddr = 3'd3; bus.DataIn = 8'h2A; bus.WriteEn = 1'b1;
        push("t2_pre", K_REGA, 3, 8'h00); drain();
        @(negedge Clk);
        bus.WriteEn = 1'b0;
        mdl[3] = 8'h2A;
        push_all("t2"); drain();

        // 3: swap r1<->r2, write to r5 during SWAP2 dropped
        write_op(3'd1, 8'h11);
        write_op(3'd2, 8'h22);
        swap_op(1'b0, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 4'h0, 3'd5, 8'h77);
        push_all("t3"); drain();

        // 4: masked flag loads
        flag_op(4'b1000, 4'b1100);
        push("t4a_flags", K_FLAGS, 0, 8'h08); push("t4a_sc", K_SC, 0, 8'h01); drain();
        flag_op(4'b0100, 4'b0000);
        push("t4b_flags", K_FLAGS, 0, 8'h08); push("t4b_sc", K_SC, 0, 8'h01); drain();

        // back-to-back swap accepted on the cycle Busy falls
        swap_op(1'b0, 3'd1, 3'd3, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 4'h0, 3'd6, 8'h99);
        swap_op(1'b1, 3'd3, 3'd2, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 4'h0, 3'd1, 8'h55);
        push_all("b2b"); drain();

        // 5: reset during SWAP2
        @(negedge Clk);
        bus.RaddrA = 3'd1; bus.RaddrB = 3'd2; bus.SwapReq = 1'b1;
        @(negedge Clk);
        bus.SwapReq = 1'b0; Reset = 1'b1;
        push("t5_busy_pre", K_BUSY, 0, 8'h01); drain();
        @(negedge Clk);
        Reset = 1'b0;
        clear_model();
        push_all("t5"); drain();

        // 6: degenerate swap keeps the write; real swap drops it, flags still load
        write_op(3'd4, 8'h44);
        swap_op(1'b0, 3'd4, 3'd4, 1'b1, 3'd6, 8'h5A, 1'b0, 4'h0, 4'h0, 3'd0, 8'h00);
        push_all("t6a"); drain();
        write_op(3'd7, 8'hC3);
        swap_op(1'b0, 3'd0, 3'd7, 1'b1, 3'd0, 8'hFF, 1'b1, 4'b0011, 4'b0101, 3'd3, 8'hEE);
        push_all("t6b"); drain();

        // random mix against the model
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: write_op(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
                1: flag_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                default: swap_op(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            endcase
            push_all($sformatf("rnd%0d", n)); drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
